// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches a multiplexed, active-low 7-segment bus and recovers the hex
//   nibble shown on each digit. A pattern is captured only once the
//   synchronized {dig_sel, seg_in} has held for STABLE_CYCLES clocks.
//   Blank (all-off) and illegal patterns are flagged per digit.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   seg_in       active-low segments, [0]=a ... [6]=g
//   dig_sel      active-high one-hot digit select
//   hex_out      decoded nibble per digit, slot i at [4i+3:4i]
//   digit_valid  slot i's last capture was a legal hex glyph
//   digit_blank  slot i's last capture was all-off
//   upd          one-cycle pulse on every capture
//   upd_idx      slot written by the current upd
//   pattern_err  one-cycle pulse with upd when the captured pattern is illegal
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    pattern_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [0:6]            seg_m, s_seg, p_seg;
  logic [NUM_DIGITS-1:0] sel_m, s_sel, p_sel;
  logic [CW-1:0]         cnt;

  logic same, onehot, cap;
  logic [4:0] dec;

  // {legal, nibble}; pattern bit string is seg[0..6] with 0 = lit
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0001100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    same   = ({s_sel, s_seg} == {p_sel, p_seg});
    onehot = (s_sel != '0) && ((s_sel & (s_sel - 1'b1)) == '0);
    dec    = decode(s_seg);
    // A change restarts the count at 1: the new value has already been
    // present for one clock when the difference is seen. The !upd term keeps
    // captures at least two cycles apart when STABLE_CYCLES is 1.
    if (!onehot || upd)
      cap = 1'b0;
    else if (same)
      cap = (cnt == CNT_LAST);
    else
      cap = (STABLE_CYCLES == 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_m       <= '0;
      s_seg       <= '0;
      p_seg       <= '0;
      sel_m       <= '0;
      s_sel       <= '0;
      p_sel       <= '0;
      cnt         <= '0;
      hex_out     <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      pattern_err <= 1'b0;
    end else begin
      seg_m <= seg_in;
      s_seg <= seg_m;
      sel_m <= dig_sel;
      s_sel <= sel_m;
      p_seg <= s_seg;
      p_sel <= s_sel;

      if (!onehot)
        cnt <= '0;
      else if (!same)
        cnt <= CW'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      upd         <= cap;
      pattern_err <= 1'b0;

      if (cap) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_sel[i]) begin
            upd_idx <= IDX_W'(i);
            if (dec[4]) begin
              hex_out[4*i +: 4] <= dec[3:0];
              digit_valid[i]    <= 1'b1;
              digit_blank[i]    <= 1'b0;
            end else if (s_seg == 7'b1111111) begin
              digit_valid[i]    <= 1'b0;
              digit_blank[i]    <= 1'b1;
            end else begin
              digit_valid[i]    <= 1'b0;
              digit_blank[i]    <= 1'b0;
              pattern_err       <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length model on raw input samples
// predicts every output each cycle; directed checks pin the model.
module tb_seg7_scan_decoder;

  localparam int ND = 6;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:6]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0] digit_valid, digit_blank;
  logic          upd, pattern_err;
  logic [2:0]    upd_idx;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .upd(upd), .upd_idx(upd_idx), .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- model ----------------
  logic [3:0] m_nib [ND];
  logic       m_val [ND];
  logic       m_blk [ND];
  logic       m_upd, m_perr;
  logic [2:0] m_idx;
  logic [ND+6:0] last_v, pend_v;
  int  runlen;
  logic pend;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ND; i++) begin
        m_nib[i] = 4'h0; m_val[i] = 1'b0; m_blk[i] = 1'b0;
      end
      m_upd = 1'b0; m_perr = 1'b0; m_idx = 3'd0;
      last_v = '0; runlen = 0; pend = 1'b0; pend_v = '0;
    end else begin
      m_upd = 1'b0; m_perr = 1'b0;
      if (pend) begin
        int d; int g;
        logic [6:0] sg;
        d = 0; g = -1;
        sg = pend_v[6:0];
        for (int i = 0; i < ND; i++) if (pend_v[7+i]) d = i;
        for (int k = 0; k < 16; k++) if (glyph[k] == sg) g = k;
        m_upd = 1'b1;
        m_idx = 3'(d);
        if (g >= 0) begin
          m_nib[d] = 4'(g); m_val[d] = 1'b1; m_blk[d] = 1'b0;
        end else if (sg == 7'h7F) begin
          m_val[d] = 1'b0; m_blk[d] = 1'b1;
        end else begin
          m_val[d] = 1'b0; m_blk[d] = 1'b0; m_perr = 1'b1;
        end
      end
      // Synchronizer delay is absorbed by resolving one edge later.
      if ({dig_sel, seg_in} == last_v) runlen++;
      else begin runlen = 1; last_v = {dig_sel, seg_in}; end
      pend = ($countones(dig_sel) == 1) && (runlen == SC + 1);
      pend_v = last_v;
    end
  end

  // ---------------- compare ----------------
  int upd_cnt = 0, perr_cnt = 0, upd_cyc = 0, perr_idx = 0;

  always @(negedge clk) begin
    logic [4*ND-1:0] eh;
    logic [ND-1:0] ev, eb;
    for (int i = 0; i < ND; i++) begin
      eh[4*i +: 4] = m_nib[i]; ev[i] = m_val[i]; eb[i] = m_blk[i];
    end
    n_cmp++;
    if (hex_out !== eh || digit_valid !== ev || digit_blank !== eb ||
        upd !== m_upd || pattern_err !== m_perr || (m_upd && upd_idx !== m_idx)) begin
      n_err++;
      $display("FAIL model cyc=%0d got hex=%h val=%b blk=%b upd=%b idx=%0d perr=%b want hex=%h val=%b blk=%b upd=%b idx=%0d perr=%b",
               cyc, hex_out, digit_valid, digit_blank, upd, upd_idx, pattern_err,
               eh, ev, eb, m_upd, m_idx, m_perr);
    end
    if (upd === 1'b1) begin upd_cnt++; upd_cyc = cyc; end
    if (pattern_err === 1'b1) begin perr_cnt++; perr_idx = int'(upd_idx); end
  end

  // ---------------- directed ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] sg, input int n);
    dig_sel = sel;
    seg_in  = sg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int u0, p0, s0, r0;
    reset = 1'b1;
    dig_sel = '0; seg_in = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      dig_sel = ND'($urandom); seg_in = 7'($urandom);
    end
    check("reset_hex", 32'(hex_out), 32'h0);
    check("reset_flags", {20'h0, digit_valid, digit_blank}, 32'h0);
    check("reset_pulses", {29'h0, upd, pattern_err, 1'b0}, 32'h0);
    dig_sel = '0; seg_in = '0;
    @(posedge clk); #2;
    reset = 1'b0;

    // after release with inputs idle, nothing captures
    u0 = upd_cnt;
    drive('0, 7'h7F, SC + 1);
    check("release_no_upd", 32'(upd_cnt - u0), 32'd0);

    // basic capture: digit 0 shows 3
    u0 = upd_cnt; s0 = cyc;
    drive(6'b000001, 7'b0000110, 10);
    check("basic_one_upd", 32'(upd_cnt - u0), 32'd1);
    check("basic_latency", 32'(upd_cyc - s0), 32'd6);
    check("basic_idx", 32'(upd_idx), 32'd0);
    check("basic_nibble", 32'(hex_out[3:0]), 32'h3);
    check("basic_valid", 32'(digit_valid), 32'h01);

    // round trip through all glyphs on all digits
    u0 = upd_cnt; p0 = perr_cnt;
    for (int v = 0; v < 16; v++)
      for (int d = 0; d < ND; d++)
        drive(ND'(1 << d), glyph[v], 8);
    check("rt_upd_count", 32'(upd_cnt - u0), 32'd96);
    check("rt_no_perr", 32'(perr_cnt - p0), 32'd0);
    check("rt_hex", 32'(hex_out), 32'hFFFFFF);
    check("rt_valid", 32'(digit_valid), 32'h3F);

    // glitch rejection
    u0 = upd_cnt;
    drive(6'b000001, glyph[1], 3);
    drive(6'b000001, glyph[2], 3);
    drive(6'b000000, glyph[4], 20);
    drive(6'b000011, glyph[4], 20);
    check("glitch_no_upd", 32'(upd_cnt - u0), 32'd0);

    // illegal and blank on digit 2
    drive(6'b000100, glyph[15], 8);
    p0 = perr_cnt;
    drive(6'b000100, 7'b1010101, 8);
    check("illegal_perr", 32'(perr_cnt - p0), 32'd1);
    check("illegal_idx", 32'(perr_idx), 32'd2);
    check("illegal_valid2", 32'(digit_valid[2]), 32'd0);
    check("illegal_hex2", 32'(hex_out[11:8]), 32'hF);
    drive(6'b000100, 7'b1111111, 8);
    check("blank2", 32'(digit_blank[2]), 32'd1);
    check("blank_valid2", 32'(digit_valid[2]), 32'd0);
    check("blank_hex2", 32'(hex_out[11:8]), 32'hF);

    // reset mid-window (count has reached 2)
    drive(6'b000001, glyph[9], 4);
    reset = 1'b1;
    #1;
    check("midrst_hex", 32'(hex_out), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    r0 = cyc;
    check("midrst_cleared", {20'h0, digit_valid, digit_blank}, 32'h0);
    u0 = upd_cnt;
    repeat (10) @(posedge clk);
    #2;
    check("midrst_one_upd", 32'(upd_cnt - u0), 32'd1);
    check("midrst_latency", 32'(upd_cyc - r0), 32'(SC + 2));
    check("midrst_nibble", 32'(hex_out), 32'h000009);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
